// File: rtl/alu_seq_ctrl.sv
// Multi-cycle command sequencer around a 32-bit combinational ALU with a local
// register file; iterates the single-bit ROR to give rotate-by-N.
module alu_seq_ctrl #(
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_en,
    input  logic [REG_AW-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic [REG_AW-1:0] cmd_rs1,
    input  logic [REG_AW-1:0] cmd_rs2,
    input  logic [4:0]        cmd_cnt,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic              busy,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [31:0]       dbg_data
);

    localparam int NREG = 1 << REG_AW;

    localparam logic [3:0] OP_ADD  = 4'b1010;
    localparam logic [3:0] OP_SUB  = 4'b1011;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b1101;
    localparam logic [3:0] OP_NOT  = 4'b1110;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_XNOR = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e            state_q, state_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       res_q, res_d;
    logic [3:0]        op_q, op_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [4:0]        rem_q, rem_d;
    logic              err_q, err_d;
    logic [31:0]       rf_q [NREG];
    logic [31:0]       rf_d [NREG];

    logic [31:0]       alu_out;
    logic              alu_illegal;

    // Combinational ALU: ROR rotates right by exactly one bit.
    always_comb begin
        alu_out     = '0;
        alu_illegal = 1'b0;
        unique case (op_q)
            OP_ADD:  alu_out = a_q + b_q;
            OP_SUB:  alu_out = a_q - b_q;
            OP_OR:   alu_out = a_q | b_q;
            OP_AND:  alu_out = a_q & b_q;
            OP_NOT:  alu_out = ~a_q;
            OP_XOR:  alu_out = a_q ^ b_q;
            OP_XNOR: alu_out = ~(a_q ^ b_q);
            OP_ROR:  alu_out = {a_q[0], a_q[31:1]};
            default: alu_illegal = 1'b1;
        endcase
    end

    // NOTE: every _d gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rem_d   = rem_q;
        err_d   = err_q;
        rf_d    = rf_q;

        unique case (state_q)
            IDLE: begin
                if (ld_en) begin
                    rf_d[ld_addr] = ld_data;
                end else if (cmd_valid) begin
                    a_d     = rf_q[cmd_rs1];
                    b_d     = rf_q[cmd_rs2];
                    op_d    = cmd_op;
                    rd_d    = cmd_rd;
                    rem_d   = cmd_cnt;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (alu_illegal) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (op_q == OP_ROR) begin
                    if (rem_q != 5'd0) begin
                        a_d   = alu_out;
                        rem_d = rem_q - 5'd1;
                    end else begin
                        res_d       = a_q;
                        rf_d[rd_q]  = a_q;
                        state_d     = RESP;
                    end
                end else begin
                    res_d      = alu_out;
                    rf_d[rd_q] = alu_out;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the register file is reset along with the control state, so it is
    // built from resettable flops rather than an inferred RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates keep every flop sampling pre-edge values.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            rf_q    <= rf_d;
        end
    end

    // Outputs decode straight from flops; only cmd_ready sees the load strobe.
    assign cmd_ready = (state_q == IDLE) && !ld_en;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = res_q;
    assign rsp_zero  = (state_q == RESP) && (res_q == 32'd0);
    assign rsp_err   = err_q;
    assign dbg_data  = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: hand-computed results, latencies and
// handshake behaviour, including back-pressure and reset mid-rotate.
module tb_alu_seq_ctrl;

    localparam logic [3:0] OP_ADD  = 4'b1010;
    localparam logic [3:0] OP_SUB  = 4'b1011;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b1101;
    localparam logic [3:0] OP_NOT  = 4'b1110;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_XNOR = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [31:0] ld_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_rs1;
    logic [2:0]  cmd_rs2;
    logic [4:0]  cmd_cnt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_zero;
    logic        rsp_err;
    logic        busy;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq_ctrl #(.REG_AW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rs1   (cmd_rs1),
        .cmd_rs2   (cmd_rs2),
        .cmd_cnt   (cmd_cnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; the load lands on the next rising edge.
    task automatic preload(input logic [2:0] addr, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        @(posedge clk);
        #1 ld_en = 1'b0;
        @(negedge clk);
    endtask

    // Counts falling edges after the accept edge until rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
    endtask

    task automatic read_dbg(input logic [2:0] addr, output logic [31:0] val);
        dbg_addr = addr;
        #1 val = dbg_data;
    endtask

    task automatic run_cmd(input string tag, input logic [3:0] op, input logic [2:0] rd,
                           input logic [2:0] rs1, input logic [2:0] rs2, input logic [4:0] cnt,
                           input logic [31:0] exp_data, input int exp_lat, input logic exp_err);
        int          lat;
        logic [31:0] rv;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        cmd_cnt   = cnt;
        cmd_valid = 1'b1;
        #1 check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_rsp(lat);
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".data"}, rsp_data, exp_data);
        check({tag, ".zero"}, 32'(rsp_zero), 32'(exp_data == 32'd0));
        check({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, ".valid_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, ".err_clear"}, 32'(rsp_err), 32'd0);
        if (!exp_err) begin
            read_dbg(rd, rv);
            check({tag, ".rf_wr"}, rv, exp_data);
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] rv;

        rst_n     = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_rd    = '0;
        cmd_rs1   = '0;
        cmd_rs2   = '0;
        cmd_cnt   = '0;
        rsp_ready = 1'b0;
        dbg_addr  = '0;
        repeat (3) @(negedge clk);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_data", rsp_data, 32'd0);
        check("rst.rsp_zero", 32'(rsp_zero), 32'd0);
        check("rst.rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle.cmd_ready", 32'(cmd_ready), 32'd1);

        // Wrap-around add giving zero.
        preload(3'd1, 32'hFFFF_FFFF);
        preload(3'd2, 32'h0000_0001);
        run_cmd("add", OP_ADD, 3'd3, 3'd1, 3'd2, 5'd0, 32'h0000_0000, 2, 1'b0);

        // Subtract below zero, then a read-after-write of the new r4.
        preload(3'd1, 32'd5);
        preload(3'd2, 32'd7);
        run_cmd("sub",  OP_SUB,  3'd4, 3'd1, 3'd2, 5'd0, 32'hFFFF_FFFE, 2, 1'b0);
        run_cmd("xnor", OP_XNOR, 3'd5, 3'd4, 3'd4, 5'd0, 32'hFFFF_FFFF, 2, 1'b0);
        run_cmd("or",   OP_OR,   3'd7, 3'd1, 3'd2, 5'd0, 32'h0000_0007, 2, 1'b0);
        run_cmd("and",  OP_AND,  3'd7, 3'd1, 3'd2, 5'd0, 32'h0000_0005, 2, 1'b0);
        run_cmd("xor",  OP_XOR,  3'd7, 3'd1, 3'd2, 5'd0, 32'h0000_0002, 2, 1'b0);
        run_cmd("not",  OP_NOT,  3'd7, 3'd1, 3'd2, 5'd0, 32'hFFFF_FFFA, 2, 1'b0);

        // Rotates: n, zero, maximum, and rd aliasing rs1.
        preload(3'd1, 32'h0000_0001);
        run_cmd("ror4",  OP_ROR, 3'd6, 3'd1, 3'd0, 5'd4,  32'h1000_0000, 6,  1'b0);
        run_cmd("ror0",  OP_ROR, 3'd6, 3'd1, 3'd0, 5'd0,  32'h0000_0001, 2,  1'b0);
        run_cmd("ror31", OP_ROR, 3'd6, 3'd1, 3'd0, 5'd31, 32'h0000_0002, 33, 1'b0);
        run_cmd("ror_alias", OP_ROR, 3'd6, 3'd6, 3'd0, 5'd1, 32'h0000_0001, 3, 1'b0);

        // Illegal opcode: error flagged, zero data, r2 keeps 7.
        run_cmd("illegal", 4'b0000, 3'd2, 3'd1, 3'd1, 5'd0, 32'h0000_0000, 2, 1'b1);
        read_dbg(3'd2, rv);
        check("illegal.rf_keep", rv, 32'd7);

        // Back-pressure: response held for 5 cycles while a new command waits.
        cmd_op = OP_ADD; cmd_rd = 3'd7; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2; cmd_cnt = '0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 begin
            cmd_op = OP_XOR; cmd_rd = 3'd0;
        end
        wait_rsp(lat);
        check("hold.latency", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold.valid", 32'(rsp_valid), 32'd1);
            check("hold.data", rsp_data, 32'd8);
            check("hold.cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("hold.valid_drop", 32'(rsp_valid), 32'd0);
        check("hold.idle_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_rsp(lat);
        check("next.latency", 32'(lat), 32'd2);
        check("next.data", rsp_data, 32'd6);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);

        // Load and command together: the load wins, command goes next cycle.
        ld_en = 1'b1; ld_addr = 3'd3; ld_data = 32'h0000_1234;
        cmd_op = OP_ADD; cmd_rd = 3'd4; cmd_rs1 = 3'd3; cmd_rs2 = 3'd3;
        cmd_valid = 1'b1;
        #1 check("ldcmd.ready_low", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1 ld_en = 1'b0;
        @(negedge clk);
        check("ldcmd.not_taken", 32'(busy), 32'd0);
        check("ldcmd.ready_high", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_rsp(lat);
        check("ldcmd.latency", 32'(lat), 32'd2);
        check("ldcmd.data", rsp_data, 32'h0000_2468);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);

        // Reset in the middle of a long rotate.
        cmd_op = OP_ROR; cmd_rd = 3'd5; cmd_rs1 = 3'd1; cmd_cnt = 5'd20;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("abort.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.rsp_valid", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            read_dbg(3'(i), rv);
            check("abort.rf_clear", rv, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort.stays_idle", 32'(busy), 32'd0);
        check("abort.no_rsp", 32'(rsp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
